breg_cycle_seq: RTL and testbench
=================================

// Module: breg_cycle_seq
// PURPOSE
//  Sequences one register-space bus cycle on the FEC board register interface.
//  - Qualifies SBSELECT/REGSPACE and latches the address and direction.
//  - Produces timed, glitch-free REG_RD_n/REG_WR_n/FIFOREG strobes.
//  - Returns DTACK_n, or BERR_n for an unclaimed address.
//  Sits between the sequencer bus slave and the register bank; replaces untimed combinational strobes.
// PARAMETERS
//  SETUP_CYCLES    2   address/direction settle time before strobe; legal range 1..15
//  STROBE_CYCLES   3   strobe low width; legal range 1..15
//  TIMEOUT_CYCLES  64  wait before BERR_n for an unclaimed address; legal range 1..255
// PORTS
//  CCLK          in   1   board clock; all logic on rising edge
//  RESET         in   1   synchronous, active-high reset
//  SBSELECT      in   1   bus slave select, high = cycle in progress
//  SBREAD_n      in   1   direction, low = read; sampled with address
//  REGSPACE      in   1   high = address is in register space
//  A             in   9   word address A[10:2]
//  REG_RD_n      out  16  per-register read strobes, active low
//  REG_WR_n      out  16  per-register write strobes, active low
//  FIFOREG_RD_n  out  1   FIFO data register read strobe, active low
//  FIFOREG_WR_n  out  1   FIFO data register write strobe, active low
//  DTACK_n       out  1   data acknowledge, active low
//  BERR_n        out  1   bus error, active low
//  BUSY          out  1   high whenever the state is not IDLE
// BEHAVIOUR
//  Reset
//  - Every strobe, DTACK_n and BERR_n is 1; BUSY is 0; state is IDLE.
//  - RESET in any state returns to IDLE on the next edge, strobes high.
//  - No partial strobe is extended past reset.
//  Decode (on latched A, LA)
//  - Register hit: LA[10:6]==0; index = LA[5:2].
//  - FIFO hit: LA[10:6]==5'b00001 and LA[5:4]==2'b11.
//  - Anything else is unclaimed.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  State machine
//  - IDLE: on SBSELECT & REGSPACE, latch A and SBREAD_n, load the counter, go to SETUP.
//  - SETUP: lasts SETUP_CYCLES cycles.
//    - SBSELECT low: go to IDLE, no strobe.
//    - Count done, address claimed: go to STROBE.
//    - Count done, unclaimed: go to WAITTO.
//  - STROBE: exactly one decoded strobe is low for exactly STROBE_CYCLES cycles.
//    - The strobe is never truncated.
//    - If SBSELECT was low on any cycle of STROBE, go to RELEASE with no DTACK; otherwise go to ACK.
//  - ACK: DTACK_n is low. When SBSELECT is sampled low, DTACK_n goes high and the state goes to RELEASE.
//  - WAITTO: counts TIMEOUT_CYCLES.
//    - SBSELECT low: go to IDLE.
//    - Count done: go to BERR.
//  - BERR: BERR_n is low until SBSELECT is sampled low, then go to RELEASE.
//  - RELEASE: one cycle with all outputs inactive, then IDLE.
//    - Guarantees one dead cycle between back-to-back cycles.
//    - A held SBSELECT does not retrigger; IDLE requires SBSELECT to have been low at least once since the last cycle.
//  Latency
//  - SBSELECT is first sampled high at edge k.
//  - Strobe low from edge k+1+SETUP_CYCLES through edge k+SETUP_CYCLES+STROBE_CYCLES.
//  - DTACK_n low at edge k+1+SETUP_CYCLES+STROBE_CYCLES.
//  Input rules
//  - Changes to A and SBREAD_n after latching are ignored.
//  - REGSPACE low at the latch edge means the cycle is not taken; the block stays IDLE.
// TESTING
//  1 Write, register 5, defaults: SBSELECT=1, SBREAD_n=1, A=9'h005 at edge 0.
//    -> REG_WR_n[5] low at edges 3..5; DTACK_n low from edge 6.
//    -> SBSELECT drops at edge 9: DTACK_n high at edge 10, IDLE at edge 11.
//  2 FIFO read, A=9'h01C, SBREAD_n=0.
//    -> FIFOREG_RD_n low for 3 cycles; all REG_RD_n remain 16'hFFFF; DTACK_n follows.
//  3 Unclaimed address, A=9'h100.
//    -> No strobe; BERR_n low at edge 3+64; BERR_n released the cycle after SBSELECT drops.
//  4 Abort: SBSELECT drops during SETUP -> no strobe, no DTACK.
//    Abort: SBSELECT drops during STROBE -> full 3-cycle strobe, DTACK_n stays 1.
//  5 RESET asserted during STROBE -> next edge: all strobes high, BUSY=0.
//    SBSELECT held high across reset -> no new cycle until it has been low.
//  6 Back-to-back cycles, reg 0 read then reg 15 write -> exactly one dead cycle between them.
//    Strobes are never overlapping; the address change mid-cycle is ignored.

Source files
------------

// File: rtl/breg_cycle_seq.sv
// Register-space bus cycle sequencer: latches address/direction, drives timed
// active-low register/FIFO strobes, then answers with DTACK_n or BERR_n.
`timescale 1ns/1ps

module breg_cycle_seq #(
   parameter int unsigned SETUP_CYCLES   = 2,
   parameter int unsigned STROBE_CYCLES  = 3,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        CCLK,
   input  logic        RESET,
   input  logic        SBSELECT,
   input  logic        SBREAD_n,
   input  logic        REGSPACE,
   input  logic [8:0]  A,
   output logic [15:0] REG_RD_n,
   output logic [15:0] REG_WR_n,
   output logic        FIFOREG_RD_n,
   output logic        FIFOREG_WR_n,
   output logic        DTACK_n,
   output logic        BERR_n,
   output logic        BUSY
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_ACK, S_WAITTO, S_BERR, S_RELEASE
   } state_e;

   // Counters load N (setup) or N-1 (strobe, timeout) and advance on zero,
   // which lines the strobe and acknowledge up with the bus latency figures.
   localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYCLES);
   localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [8:0]  la_q, la_d;
   logic        read_q, read_d;
   logic        abort_q, abort_d;
   logic        armed_q, armed_d;
   logic [15:0] reg_rd_n_q, reg_rd_n_d;
   logic [15:0] reg_wr_n_q, reg_wr_n_d;
   logic        fifo_rd_n_q, fifo_rd_n_d;
   logic        fifo_wr_n_q, fifo_wr_n_d;
   logic        dtack_n_q, dtack_n_d;
   logic        berr_n_q, berr_n_d;
   logic        busy_q, busy_d;

   logic        reg_hit;
   logic        fifo_hit;
   logic [15:0] reg_sel;

   // la_q holds A[10:2], so LA[10:6] is la_q[8:4] and LA[5:2] is la_q[3:0].
   assign reg_hit  = (la_q[8:4] == 5'b00000);
   assign fifo_hit = (la_q[8:4] == 5'b00001) && (la_q[3:2] == 2'b11);
   assign reg_sel  = 16'h0001 << la_q[3:0];

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      la_d        = la_q;
      read_d      = read_q;
      abort_d     = abort_q;
      armed_d     = armed_q | ~SBSELECT;
      reg_rd_n_d  = '1;
      reg_wr_n_d  = '1;
      fifo_rd_n_d = 1'b1;
      fifo_wr_n_d = 1'b1;
      dtack_n_d   = 1'b1;
      berr_n_d    = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (SBSELECT && REGSPACE && armed_q) begin
               la_d    = A;
               read_d  = ~SBREAD_n;
               cnt_d   = SETUP_LD;
               armed_d = 1'b0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (!SBSELECT) begin
               state_d = S_IDLE;
            end else if (cnt_q == 8'd0) begin
               abort_d = 1'b0;
               if (reg_hit || fifo_hit) begin
                  state_d = S_STROBE;
                  cnt_d   = STROBE_LD;
                  if (reg_hit) begin
                     if (read_q) reg_rd_n_d = ~reg_sel;
                     else        reg_wr_n_d = ~reg_sel;
                  end else begin
                     if (read_q) fifo_rd_n_d = 1'b0;
                     else        fifo_wr_n_d = 1'b0;
                  end
               end else begin
                  state_d = S_WAITTO;
                  cnt_d   = TIMEOUT_LD;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_STROBE: begin
            abort_d = abort_q | ~SBSELECT;
            if (cnt_q == 8'd0) begin
               if (abort_q || !SBSELECT) begin
                  state_d = S_RELEASE;
               end else begin
                  state_d   = S_ACK;
                  dtack_n_d = 1'b0;
               end
            end else begin
               cnt_d       = cnt_q - 8'd1;
               reg_rd_n_d  = reg_rd_n_q;
               reg_wr_n_d  = reg_wr_n_q;
               fifo_rd_n_d = fifo_rd_n_q;
               fifo_wr_n_d = fifo_wr_n_q;
            end
         end
         S_ACK: begin
            if (!SBSELECT) state_d = S_RELEASE;
            else           dtack_n_d = 1'b0;
         end
         S_WAITTO: begin
            if (!SBSELECT) begin
               state_d = S_IDLE;
            end else if (cnt_q == 8'd0) begin
               state_d  = S_BERR;
               berr_n_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_BERR: begin
            if (!SBSELECT) state_d = S_RELEASE;
            else           berr_n_d = 1'b0;
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CCLK) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      if (RESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         la_q        <= '0;
         read_q      <= 1'b0;
         abort_q     <= 1'b0;
         armed_q     <= 1'b0;
         reg_rd_n_q  <= '1;
         reg_wr_n_q  <= '1;
         fifo_rd_n_q <= 1'b1;
         fifo_wr_n_q <= 1'b1;
         dtack_n_q   <= 1'b1;
         berr_n_q    <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         la_q        <= la_d;
         read_q      <= read_d;
         abort_q     <= abort_d;
         armed_q     <= armed_d;
         reg_rd_n_q  <= reg_rd_n_d;
         reg_wr_n_q  <= reg_wr_n_d;
         fifo_rd_n_q <= fifo_rd_n_d;
         fifo_wr_n_q <= fifo_wr_n_d;
         dtack_n_q   <= dtack_n_d;
         berr_n_q    <= berr_n_d;
         busy_q      <= busy_d;
      end
   end

   assign REG_RD_n     = reg_rd_n_q;
   assign REG_WR_n     = reg_wr_n_q;
   assign FIFOREG_RD_n = fifo_rd_n_q;
   assign FIFOREG_WR_n = fifo_wr_n_q;
   assign DTACK_n      = dtack_n_q;
   assign BERR_n       = berr_n_q;
   assign BUSY         = busy_q;

endmodule

// File: tb/tb_breg_cycle_seq.sv
// Bench for breg_cycle_seq: per-edge output windows from the bus latency rules,
// plus a strobe-pulse scoreboard fed by each scenario.
`timescale 1ns/1ps

module tb_breg_cycle_seq;

   logic        CCLK = 1'b0;
   logic        RESET = 1'b1;
   logic        SBSELECT = 1'b0;
   logic        SBREAD_n = 1'b1;
   logic        REGSPACE = 1'b0;
   logic [8:0]  A = '0;
   logic [15:0] REG_RD_n;
   logic [15:0] REG_WR_n;
   logic        FIFOREG_RD_n;
   logic        FIFOREG_WR_n;
   logic        DTACK_n;
   logic        BERR_n;
   logic        BUSY;

   typedef struct {
      logic [33:0] vec;
      int          width;
   } pulse_t;

   localparam logic [36:0] IDLE_OUT = {{34{1'b1}}, 3'b110};

   pulse_t      exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [33:0] mon_vec;
   logic [33:0] mon_first;
   int          mon_width;
   bit          in_pulse = 1'b0;

   breg_cycle_seq dut (
      .CCLK         (CCLK),
      .RESET        (RESET),
      .SBSELECT     (SBSELECT),
      .SBREAD_n     (SBREAD_n),
      .REGSPACE     (REGSPACE),
      .A            (A),
      .REG_RD_n     (REG_RD_n),
      .REG_WR_n     (REG_WR_n),
      .FIFOREG_RD_n (FIFOREG_RD_n),
      .FIFOREG_WR_n (FIFOREG_WR_n),
      .DTACK_n      (DTACK_n),
      .BERR_n       (BERR_n),
      .BUSY         (BUSY)
   );

   always #5 CCLK = ~CCLK;

   function automatic logic [36:0] outs();
      return {REG_RD_n, REG_WR_n, FIFOREG_RD_n, FIFOREG_WR_n, DTACK_n, BERR_n, BUSY};
   endfunction

   task automatic tick();
      @(posedge CCLK);
      #1;
   endtask

   // Pulse monitor: one strobe low at a time, stable for the whole pulse,
   // and matching the next expected pulse in vector and width.
   initial begin
      pulse_t p;
      forever begin
         @(posedge CCLK);
         #1;
         mon_vec = {REG_RD_n, REG_WR_n, FIFOREG_RD_n, FIFOREG_WR_n};
         if (mon_vec !== '1) begin
            n_tests++;
            if ($countones(~mon_vec) != 1) begin
               n_fail++;
               $display("FAIL strobe_onehot: got %h, want exactly one low bit", mon_vec);
            end
            if (!in_pulse) begin
               in_pulse  = 1'b1;
               mon_first = mon_vec;
               mon_width = 1;
            end else begin
               mon_width++;
               n_tests++;
               if (mon_vec !== mon_first) begin
                  n_fail++;
                  $display("FAIL strobe_stable: got %h, want %h", mon_vec, mon_first);
               end
            end
         end else if (in_pulse) begin
            in_pulse = 1'b0;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL strobe_unexpected: got %h width %0d, want no pulse", mon_first, mon_width);
            end else begin
               p = exp_q.pop_front();
               if (mon_first !== p.vec || mon_width != p.width) begin
                  n_fail++;
                  $display("FAIL strobe_pulse: got %h width %0d, want %h width %0d",
                           mon_first, mon_width, p.vec, p.width);
               end
            end
         end
      end
   end

   // One bus cycle. Edge 0 is the first edge sampling SBSELECT high after `pre`
   // dead edges. Each window [lo,hi] is the range of edges after which that
   // output must be active; SBSELECT drops right after edge drop_at, and A /
   // SBREAD_n are scrambled after edge 1 to show they are not re-sampled.
   task automatic run_cycle(input string name, input logic [8:0] a, input logic rd_n,
                            input logic [33:0] act, input int pre, input int drop_at,
                            input int last_edge, input int stb_lo, input int stb_hi,
                            input int ack_lo, input int ack_hi, input int berr_lo,
                            input int berr_hi, input int busy_hi);
      logic [36:0] exp_v;
      pulse_t      p;
      if (stb_hi >= stb_lo) begin
         p.vec   = act;
         p.width = stb_hi - stb_lo + 1;
         exp_q.push_back(p);
      end
      SBSELECT = 1'b1;
      REGSPACE = 1'b1;
      A        = a;
      SBREAD_n = rd_n;
      for (int i = 0; i < pre; i++) begin
         tick();
         n_tests++;
         if (outs() !== IDLE_OUT) begin
            n_fail++;
            $display("FAIL %s dead_cycle: got %h, want %h", name, outs(), IDLE_OUT);
         end
      end
      for (int e = 0; e <= last_edge; e++) begin
         tick();
         exp_v[36:3] = (e >= stb_lo && e <= stb_hi) ? act : '1;
         exp_v[2]    = !(e >= ack_lo && e <= ack_hi);
         exp_v[1]    = !(e >= berr_lo && e <= berr_hi);
         exp_v[0]    = (e <= busy_hi);
         n_tests++;
         if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %h, want %h", name, e, outs(), exp_v);
         end
         if (e == 1) begin
            A        = a ^ 9'h1FF;
            SBREAD_n = ~rd_n;
         end
         if (e == drop_at) SBSELECT = 1'b0;
      end
   endtask

   task automatic test_reset();
      RESET    = 1'b1;
      SBSELECT = 1'b0;
      tick();
      tick();
      n_tests++;
      if (outs() !== IDLE_OUT) begin
         n_fail++;
         $display("FAIL reset_state: got %h, want %h", outs(), IDLE_OUT);
      end
      RESET = 1'b0;
      tick();
      n_tests++;
      if (outs() !== IDLE_OUT) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %h, want %h", outs(), IDLE_OUT);
      end
   endtask

   task automatic test_write_reg();
      run_cycle("write_reg5", 9'h005, 1'b1, {16'hFFFF, 16'hFFDF, 2'b11},
                0, 9, 11, 3, 5, 6, 9, -1, -2, 10);
   endtask

   task automatic test_fifo_read();
      run_cycle("fifo_read", 9'h01C, 1'b0, {16'hFFFF, 16'hFFFF, 2'b01},
                0, 7, 9, 3, 5, 6, 7, -1, -2, 8);
   endtask

   task automatic test_unclaimed();
      run_cycle("unclaimed", 9'h100, 1'b1, '1,
                0, 70, 72, -1, -2, -1, -2, 67, 70, 71);
   endtask

   task automatic test_abort_setup();
      run_cycle("abort_setup", 9'h003, 1'b1, '1,
                0, 2, 4, -1, -2, -1, -2, -1, -2, 2);
   endtask

   task automatic test_abort_strobe();
      run_cycle("abort_strobe", 9'h007, 1'b0, {16'hFF7F, 16'hFFFF, 2'b11},
                0, 5, 7, 3, 5, -1, -2, -1, -2, 6);
   endtask

   task automatic test_regspace();
      SBSELECT = 1'b1;
      REGSPACE = 1'b0;
      A        = 9'h005;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (outs() !== IDLE_OUT) begin
            n_fail++;
            $display("FAIL regspace_low: got %h, want %h", outs(), IDLE_OUT);
         end
      end
      SBSELECT = 1'b0;
      REGSPACE = 1'b1;
      tick();
   endtask

   task automatic test_reset_in_strobe();
      pulse_t p;
      p.vec   = {16'hFFFF, 16'hFDFF, 2'b11};
      p.width = 2;
      exp_q.push_back(p);
      SBSELECT = 1'b1;
      REGSPACE = 1'b1;
      A        = 9'h009;
      SBREAD_n = 1'b1;
      for (int e = 0; e <= 4; e++) tick();
      RESET = 1'b1;
      tick();
      n_tests++;
      if (outs() !== IDLE_OUT) begin
         n_fail++;
         $display("FAIL reset_in_strobe: got %h, want %h", outs(), IDLE_OUT);
      end
      RESET = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL held_select_no_retrigger: got BUSY=%b, want 0", BUSY);
         end
      end
      SBSELECT = 1'b0;
      tick();
      SBSELECT = 1'b1;
      tick();
      n_tests++;
      if (BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL rearm_after_low: got BUSY=%b, want 1", BUSY);
      end
      SBSELECT = 1'b0;
      tick();
      tick();
      n_tests++;
      if (outs() !== IDLE_OUT) begin
         n_fail++;
         $display("FAIL rearm_abort_idle: got %h, want %h", outs(), IDLE_OUT);
      end
   endtask

   task automatic test_back_to_back();
      run_cycle("b2b_read_reg0", 9'h000, 1'b0, {16'hFFFE, 16'hFFFF, 2'b11},
                0, 7, 8, 3, 5, 6, 7, -1, -2, 8);
      run_cycle("b2b_write_reg15", 9'h00F, 1'b1, {16'hFFFF, 16'h7FFF, 2'b11},
                1, 7, 9, 3, 5, 6, 7, -1, -2, 8);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write_reg();
      test_fifo_read();
      test_unclaimed();
      test_abort_setup();
      test_abort_strobe();
      test_regspace();
      test_reset_in_strobe();
      test_back_to_back();
      tick();
      tick();
      n_tests++;
      if (exp_q.size() != 0 || in_pulse) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending pulses (in_pulse=%b), want 0",
                  exp_q.size(), in_pulse);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
